// File: rtl/vending_if.sv
// Handshake/bus bundle between the vending controller and its environment.
// The master side drives coins, selection and acknowledges; the controller (slave) drives status.
interface vending_if #(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W  = 8
);
    localparam int SEL_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

    logic                 coin_5;
    logic                 coin_10;
    logic                 coin_25;
    logic                 select;
    logic [SEL_W-1:0]     item_sel;
    logic                 cancel;
    logic [NUM_ITEMS-1:0] sold_out;
    logic                 change_ack;

    logic [CREDIT_W-1:0]  credit;
    logic                 dispense;
    logic [SEL_W-1:0]     dispense_item;
    logic                 change_valid;
    logic [CREDIT_W-1:0]  change_amount;
    logic                 coin_reject;
    logic                 sel_error;

    modport master (
        output coin_5, coin_10, coin_25, select, item_sel, cancel, sold_out, change_ack,
        input  credit, dispense, dispense_item, change_valid, change_amount, coin_reject, sel_error
    );

    modport slave (
        input  coin_5, coin_10, coin_25, select, item_sel, cancel, sold_out, change_ack,
        output credit, dispense, dispense_item, change_valid, change_amount, coin_reject, sel_error
    );
endinterface

// File: rtl/vending_controller.sv
// Coin-accepting vending controller: credit accumulation, item purchase with price check,
// one-cycle dispense pulse and held change/refund until acknowledged. All outputs registered.
//
//   state      | meaning
//   IDLE       | no credit, waiting for first coin
//   COLLECTING | credit held, accepting coins / select / cancel
//   DISPENSING | one cycle, dispense pulse active
//   CHANGE     | change_valid held until change_ack
module vending_controller #(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_TABLE = {8'd125, 8'd100, 8'd75, 8'd50}
) (
    input  logic      clk,
    input  logic      reset,
    vending_if.slave  bus
);
    localparam int SEL_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

    typedef enum logic [1:0] {IDLE, COLLECTING, DISPENSING, CHANGE} state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispense_q, dispense_d;
    logic [SEL_W-1:0]    dispense_item_q, dispense_item_d;
    logic                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0] change_amount_q, change_amount_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_error_q, sel_error_d;

    logic                coin_hit;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   credit_sum;
    logic                coin_fits;
    logic                item_known;
    logic                item_sold;
    logic [CREDIT_W-1:0] price;
    logic                select_ok;

    // Highest-value strobe wins; lower simultaneous strobes are simply dropped.
    always_comb begin
        coin_hit = 1'b1;
        coin_val = '0;
        if (bus.coin_25)      coin_val = CREDIT_W'(25);
        else if (bus.coin_10) coin_val = CREDIT_W'(10);
        else if (bus.coin_5)  coin_val = CREDIT_W'(5);
        else                  coin_hit = 1'b0;
        credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
        coin_fits  = credit_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    end

    // Table lookup by match keeps out-of-range indices from touching PRICE_TABLE/sold_out.
    always_comb begin
        item_known = 1'b0;
        item_sold  = 1'b0;
        price      = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (bus.item_sel == SEL_W'(i)) begin
                item_known = 1'b1;
                item_sold  = bus.sold_out[i];
                price      = PRICE_TABLE[i*CREDIT_W +: CREDIT_W];
            end
        end
        select_ok = item_known && !item_sold && (credit_q >= price);
    end

    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        dispense_d      = 1'b0;
        dispense_item_d = dispense_item_q;
        change_valid_d  = change_valid_q;
        change_amount_d = change_amount_q;
        coin_reject_d   = 1'b0;
        sel_error_d     = 1'b0;

        case (state_q)
            IDLE: begin
                sel_error_d = bus.select;
                if (coin_hit) begin
                    if (coin_fits) begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                        state_d  = COLLECTING;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            COLLECTING: begin
                if (bus.cancel) begin
                    state_d         = CHANGE;
                    change_valid_d  = 1'b1;
                    change_amount_d = credit_q;
                    coin_reject_d   = coin_hit;
                end else if (bus.select && select_ok) begin
                    state_d         = DISPENSING;
                    credit_d        = credit_q - price;
                    dispense_d      = 1'b1;
                    dispense_item_d = bus.item_sel;
                    coin_reject_d   = coin_hit;
                end else begin
                    sel_error_d = bus.select;
                    if (coin_hit) begin
                        if (coin_fits) credit_d = credit_sum[CREDIT_W-1:0];
                        else           coin_reject_d = 1'b1;
                    end
                end
            end
            DISPENSING: begin
                coin_reject_d = coin_hit;
                if (credit_q != '0) begin
                    state_d         = CHANGE;
                    change_valid_d  = 1'b1;
                    change_amount_d = credit_q;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_hit;
                if (bus.change_ack) begin
                    state_d         = IDLE;
                    credit_d        = '0;
                    change_valid_d  = 1'b0;
                    change_amount_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            credit_q        <= '0;
            dispense_q      <= 1'b0;
            dispense_item_q <= '0;
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
            coin_reject_q   <= 1'b0;
            sel_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            dispense_q      <= dispense_d;
            dispense_item_q <= dispense_item_d;
            change_valid_q  <= change_valid_d;
            change_amount_q <= change_amount_d;
            coin_reject_q   <= coin_reject_d;
            sel_error_q     <= sel_error_d;
        end
    end

    assign bus.credit        = credit_q;
    assign bus.dispense      = dispense_q;
    assign bus.dispense_item = dispense_item_q;
    assign bus.change_valid  = change_valid_q;
    assign bus.change_amount = change_amount_q;
    assign bus.coin_reject   = coin_reject_q;
    assign bus.sel_error     = sel_error_q;
endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller: a table of per-cycle input/expected-output records,
// then a few hand-written multi-cycle sequences (reset in CHANGE/DISPENSING, coin while busy).
module tb_vending_controller;
    localparam logic [6:0] R   = 7'b1000000;
    localparam logic [6:0] C5  = 7'b0100000;
    localparam logic [6:0] C10 = 7'b0010000;
    localparam logic [6:0] C25 = 7'b0001000;
    localparam logic [6:0] SEL = 7'b0000100;
    localparam logic [6:0] CAN = 7'b0000010;
    localparam logic [6:0] ACK = 7'b0000001;
    localparam logic [6:0] NON = 7'b0000000;

    typedef struct {
        logic [6:0] in;
        logic [1:0] item;
        logic [3:0] sold;
        logic [7:0] e_credit;
        logic       e_disp;
        logic [1:0] e_item;
        logic       e_cv;
        logic [7:0] e_amt;
        logic       e_crej;
        logic       e_serr;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    vending_if #(.NUM_ITEMS(4), .CREDIT_W(8)) bus();

    vending_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic vec_t mk(logic [6:0] in, logic [1:0] item, logic [3:0] sold,
                                logic [7:0] cr, logic disp, logic [1:0] ditem,
                                logic cv, logic [7:0] amt, logic crej, logic serr);
        vec_t v;
        v.in = in; v.item = item; v.sold = sold;
        v.e_credit = cr; v.e_disp = disp; v.e_item = ditem;
        v.e_cv = cv; v.e_amt = amt; v.e_crej = crej; v.e_serr = serr;
        return v;
    endfunction

    // Drive one cycle of inputs, let one edge pass, then compare registered outputs.
    task automatic apply(input vec_t v, input string name);
        logic ok;
        reset          = v.in[6];
        bus.coin_5     = v.in[5];
        bus.coin_10    = v.in[4];
        bus.coin_25    = v.in[3];
        bus.select     = v.in[2];
        bus.cancel     = v.in[1];
        bus.change_ack = v.in[0];
        bus.item_sel   = v.item;
        bus.sold_out   = v.sold;
        @(posedge clk);
        #1;
        ok = (bus.credit == v.e_credit) && (bus.dispense == v.e_disp) &&
             (bus.change_valid == v.e_cv) && (bus.coin_reject == v.e_crej) &&
             (bus.sel_error == v.e_serr) &&
             (!(v.e_disp || v.in[6]) || bus.dispense_item == v.e_item) &&
             (!(v.e_cv || v.in[6]) || bus.change_amount == v.e_amt);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got credit=%0d disp=%0b item=%0d cv=%0b amt=%0d crej=%0b serr=%0b; want credit=%0d disp=%0b item=%0d cv=%0b amt=%0d crej=%0b serr=%0b",
                      name, bus.credit, bus.dispense, bus.dispense_item, bus.change_valid,
                      bus.change_amount, bus.coin_reject, bus.sel_error,
                      v.e_credit, v.e_disp, v.e_item, v.e_cv, v.e_amt, v.e_crej, v.e_serr);
    endtask

    initial begin
        reset = 1'b1;
        bus.coin_5 = 0; bus.coin_10 = 0; bus.coin_25 = 0; bus.select = 0;
        bus.cancel = 0; bus.change_ack = 0; bus.item_sel = '0; bus.sold_out = '0;
        repeat (2) @(posedge clk);

        //            in         item sold  credit disp ditem cv amt crej serr
        vecs.push_back(mk(R,        0, 0,     0, 0, 0, 0,   0, 0, 0));
        // two quarters buy item 0 exactly
        vecs.push_back(mk(C25,      0, 0,    25, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(C25,      0, 0,    50, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(SEL,      0, 0,     0, 1, 0, 0,   0, 0, 0));
        vecs.push_back(mk(NON,      0, 0,     0, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(NON,      0, 0,     0, 0, 0, 0,   0, 0, 0));
        // four quarters, item 1, change 25 held until ack
        vecs.push_back(mk(C25,      0, 0,    25, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(C25,      0, 0,    50, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(C25,      0, 0,    75, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(C25,      0, 0,   100, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(SEL,      1, 0,    25, 1, 1, 0,   0, 0, 0));
        vecs.push_back(mk(NON,      0, 0,    25, 0, 0, 1,  25, 0, 0));
        vecs.push_back(mk(NON,      0, 0,    25, 0, 0, 1,  25, 0, 0));
        vecs.push_back(mk(ACK,      0, 0,     0, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(ACK,      0, 0,     0, 0, 0, 0,   0, 0, 0));
        // build to 190, overflow reject, fill to exactly 200
        for (int k = 1; k <= 7; k++)
            vecs.push_back(mk(C25,  0, 0, 8'(25*k), 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(C10,      0, 0,   185, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(C5,       0, 0,   190, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(C25,      0, 0,   190, 0, 0, 0,   0, 1, 0));
        vecs.push_back(mk(C10,      0, 0,   200, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(C5,       0, 0,   200, 0, 0, 0,   0, 1, 0));
        vecs.push_back(mk(CAN,      0, 0,   200, 0, 0, 1, 200, 0, 0));
        vecs.push_back(mk(C25,      0, 0,   200, 0, 0, 1, 200, 1, 0));
        vecs.push_back(mk(SEL,      0, 0,   200, 0, 0, 1, 200, 0, 0));
        vecs.push_back(mk(ACK,      0, 0,     0, 0, 0, 0,   0, 0, 0));
        // credit 60: too poor for item 2, item 0 sold out, then refund
        vecs.push_back(mk(C25,      0, 0,    25, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(C25,      0, 0,    50, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(C10,      0, 0,    60, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(SEL,      2, 0,    60, 0, 0, 0,   0, 0, 1));
        vecs.push_back(mk(SEL,      0, 1,    60, 0, 0, 0,   0, 0, 1));
        vecs.push_back(mk(CAN,      0, 0,    60, 0, 0, 1,  60, 0, 0));
        vecs.push_back(mk(ACK,      0, 0,     0, 0, 0, 0,   0, 0, 0));
        // coin priority and select-vs-coin collision
        vecs.push_back(mk(C5|C25,   0, 0,    25, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(C25,      0, 0,    50, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk(SEL|C10,  0, 0,     0, 1, 0, 0,   0, 1, 0));
        vecs.push_back(mk(NON,      0, 0,     0, 0, 0, 0,   0, 0, 0));
        // select and cancel while idle
        vecs.push_back(mk(SEL,      0, 0,     0, 0, 0, 0,   0, 0, 1));
        vecs.push_back(mk(CAN,      0, 0,     0, 0, 0, 0,   0, 0, 0));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // reset while holding 40 in change, then fresh coin
        apply(mk(C25, 0, 0, 25, 0, 0, 0,  0, 0, 0), "rst_chg_c25");
        apply(mk(C10, 0, 0, 35, 0, 0, 0,  0, 0, 0), "rst_chg_c10");
        apply(mk(C5,  0, 0, 40, 0, 0, 0,  0, 0, 0), "rst_chg_c5");
        apply(mk(CAN, 0, 0, 40, 0, 0, 1, 40, 0, 0), "rst_chg_cancel");
        apply(mk(NON, 0, 0, 40, 0, 0, 1, 40, 0, 0), "rst_chg_hold");
        apply(mk(R|C25, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_chg_reset");
        apply(mk(C5,  0, 0,  5, 0, 0, 0,  0, 0, 0), "rst_chg_after");
        apply(mk(CAN, 0, 0,  5, 0, 0, 1,  5, 0, 0), "rst_chg_refund");
        apply(mk(ACK, 0, 0,  0, 0, 0, 0,  0, 0, 0), "rst_chg_ack");

        // coin arriving during the dispense cycle
        for (int k = 1; k <= 4; k++)
            apply(mk(C25, 0, 0, 8'(25*k), 0, 0, 0, 0, 0, 0), $sformatf("busy_c25_%0d", k));
        apply(mk(SEL, 3, 0, 100, 0, 0, 0,  0, 0, 1), "busy_poor");
        apply(mk(SEL, 1, 0,  25, 1, 1, 0,  0, 0, 0), "busy_buy");
        apply(mk(C10, 0, 0,  25, 0, 0, 1, 25, 1, 0), "busy_coin");
        apply(mk(ACK, 0, 0,   0, 0, 0, 0,  0, 0, 0), "busy_ack");

        // reset during dispensing discards leftover credit, no change follows
        for (int k = 1; k <= 3; k++)
            apply(mk(C25, 0, 0, 8'(25*k), 0, 0, 0, 0, 0, 0), $sformatf("rst_disp_c25_%0d", k));
        apply(mk(SEL, 0, 0, 25, 1, 0, 0, 0, 0, 0), "rst_disp_buy");
        apply(mk(R,   0, 0,  0, 0, 0, 0, 0, 0, 0), "rst_disp_reset");
        apply(mk(NON, 0, 0,  0, 0, 0, 0, 0, 0, 0), "rst_disp_quiet");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
